// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch FSM encoding, reset PC and instruction field positions
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int TARGET_MSB = 25;
    localparam int TARGET_LSB = 0;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;

    // Word-aligned, sign-extended branch displacement from a 16-bit immediate.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm16);
        return {{14{imm16[15]}}, imm16, 2'b00};
    endfunction

endpackage

// File: rtl/npc_calc.sv
// rtl/npc_calc.sv - combinational next-PC selection from branch/jump controls
module npc_calc
    import cpu_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [31:0] instr,
    input  logic [31:0] rs_data,
    input  logic        Branch,
    input  logic        Zero,
    input  logic        Jump,
    input  logic        JumpReg,
    output logic [31:0] next_pc
);

    // Opcode and the low register-target bits never steer the next PC.
    logic unused_bits;
    assign unused_bits = ^{instr[OPCODE_MSB:OPCODE_LSB], rs_data[1:0]};

    // Priority: register jump, absolute jump, taken branch, fall-through.
    always_comb begin
        next_pc = pc_plus4;
        if (JumpReg) begin
            next_pc = {rs_data[31:2], 2'b00};
        end else if (Jump) begin
            next_pc = {pc_plus4[31:28], instr[TARGET_MSB:TARGET_LSB], 2'b00};
        end else if (Branch && Zero) begin
            next_pc = pc_plus4 + branch_offset(instr[IMM_MSB:IMM_LSB]);
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - PC owner and handshaked instruction fetch FSM
module instr_fetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        exec_done,
    input  logic        Branch,
    input  logic        Zero,
    input  logic        Jump,
    input  logic        JumpReg,
    input  logic [31:0] rs_data,
    output logic [31:0] retired
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  retired_q, retired_d;
    logic [31:0]  next_pc;

    assign pc_plus4  = pc_q + 32'd4;
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign instr     = instr_q;
    assign retired   = retired_q;

    npc_calc u_npc_calc (
        .pc_plus4 (pc_plus4),
        .instr    (instr_q),
        .rs_data  (rs_data),
        .Branch   (Branch),
        .Zero     (Zero),
        .Jump     (Jump),
        .JumpReg  (JumpReg),
        .next_pc  (next_pc)
    );

    // Fetch sequencing: request while in FETCH, hold the word until the datapath commits.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        retired_d   = retired_q;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    instr_d = imem_rdata;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                instr_valid = 1'b1;
                if (exec_done) begin
                    pc_d      = next_pc;
                    retired_d = retired_q + 32'd1;
                    state_d   = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_BOOT;
            pc_q      <= RESET_PC;
            instr_q   <= 32'h0;
            retired_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            retired_q <= retired_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed self-checking bench for instr_fetch
module tb_instr_fetch;
    import cpu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        exec_done;
    logic        Branch;
    logic        Zero;
    logic        Jump;
    logic        JumpReg;
    logic [31:0] rs_data;
    logic [31:0] retired;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    logic [31:0] exp_ret = 0;

    instr_fetch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .exec_done   (exec_done),
        .Branch      (Branch),
        .Zero        (Zero),
        .Jump        (Jump),
        .JumpReg     (JumpReg),
        .rs_data     (rs_data),
        .retired     (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        imem_ready = 1'b0;
        imem_rdata = 32'h0;
        exec_done  = 1'b0;
        Branch     = 1'b0;
        Zero       = 1'b0;
        Jump       = 1'b0;
        JumpReg    = 1'b0;
        rs_data    = 32'h0;
    endtask

    // Reset for n cycles, release, and step through BOOT into FETCH.
    task automatic apply_reset(input int n);
        clear_inputs();
        rst_n = 1'b0;
        repeat (n) tick();
        rst_n = 1'b1;
        tick();
        exp_ret = 0;
    endtask

    // Zero-wait fetch of one word; leaves the DUT in HOLD.
    task automatic fetch(input logic [31:0] word);
        imem_ready = 1'b1;
        imem_rdata = word;
        tick();
        imem_ready = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
    endtask

    // One-cycle exec_done pulse with the given controls; leaves the DUT in FETCH.
    task automatic commit(input logic br, input logic z, input logic j, input logic jr,
                          input logic [31:0] rs);
        Branch = br; Zero = z; Jump = j; JumpReg = jr; rs_data = rs;
        exec_done = 1'b1;
        tick();
        clear_inputs();
        exp_ret = exp_ret + 1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (pc !== 32'h3000) begin errors++; $display("FAIL reset_pc: got %h want %h", pc, 32'h3000); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_req); end
        checks++; if (retired !== 32'h0) begin errors++; $display("FAIL reset_retired: got %h want 0", retired); end
        checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 0", instr); end
        rst_n = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL boot_req: got %b want 0", imem_req); end
        tick();
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL first_req: got %b want 1", imem_req); end
        checks++; if (imem_addr !== 32'h3000) begin errors++; $display("FAIL first_addr: got %h want %h", imem_addr, 32'h3000); end
        exp_ret = 0;
    endtask

    task automatic test_sequential();
        int c0;
        c0 = cyc;
        for (int i = 0; i < 3; i++) begin
            checks++; if (imem_addr !== 32'h3000 + 32'(4 * i)) begin errors++; $display("FAIL seq_addr%0d: got %h want %h", i, imem_addr, 32'h3000 + 32'(4 * i)); end
            fetch(32'h0000_0020 + 32'(i));
            checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL seq_valid%0d: got %b want 1", i, instr_valid); end
            checks++; if (instr !== 32'h0000_0020 + 32'(i)) begin errors++; $display("FAIL seq_instr%0d: got %h want %h", i, instr, 32'h0000_0020 + 32'(i)); end
            commit(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        end
        checks++; if (retired !== 32'd3) begin errors++; $display("FAIL seq_retired: got %0d want 3", retired); end
        checks++; if (imem_addr !== 32'h300C) begin errors++; $display("FAIL seq_next_addr: got %h want %h", imem_addr, 32'h300C); end
        checks++; if (cyc - c0 !== 6) begin errors++; $display("FAIL seq_cycles: got %0d want 6", cyc - c0); end
    endtask

    task automatic test_branch();
        apply_reset(2);
        fetch(32'h0); commit(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        fetch(32'h0); commit(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checks++; if (imem_addr !== 32'h3008) begin errors++; $display("FAIL br_start: got %h want %h", imem_addr, 32'h3008); end
        fetch(32'h1000_FFFF);
        commit(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        checks++; if (imem_addr !== 32'h3008) begin errors++; $display("FAIL br_taken: got %h want %h", imem_addr, 32'h3008); end
        fetch(32'h1000_FFFF);
        commit(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        checks++; if (imem_addr !== 32'h300C) begin errors++; $display("FAIL br_not_taken: got %h want %h", imem_addr, 32'h300C); end
        fetch(32'h0); commit(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checks++; if (retired !== 32'd5) begin errors++; $display("FAIL br_retired: got %0d want 5", retired); end
    endtask

    task automatic test_jumps();
        checks++; if (imem_addr !== 32'h3010) begin errors++; $display("FAIL j_start: got %h want %h", imem_addr, 32'h3010); end
        fetch(32'h0800_0C10);
        checks++; if (pc_plus4 !== 32'h3014) begin errors++; $display("FAIL j_pc_plus4: got %h want %h", pc_plus4, 32'h3014); end
        commit(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        checks++; if (imem_addr !== 32'h0000_3040) begin errors++; $display("FAIL j_target: got %h want %h", imem_addr, 32'h3040); end
        fetch(32'h0800_0C10);
        commit(1'b0, 1'b0, 1'b1, 1'b1, 32'h3007);
        checks++; if (imem_addr !== 32'h3004) begin errors++; $display("FAIL jr_target: got %h want %h", imem_addr, 32'h3004); end
        checks++; if (retired !== exp_ret) begin errors++; $display("FAIL j_retired: got %0d want %0d", retired, exp_ret); end
    endtask

    task automatic test_wait_states();
        logic [31:0] r0;
        r0 = exp_ret;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3004) begin errors++; $display("FAIL ws_enter: req %b addr %h want 1 %h", imem_req, imem_addr, 32'h3004); end
        imem_ready = 1'b0;
        exec_done  = 1'b1;
        Jump       = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3004) begin errors++; $display("FAIL ws_hold%0d: req %b addr %h want 1 %h", i, imem_req, imem_addr, 32'h3004); end
            checks++; if (instr_valid !== 1'b0 || pc !== 32'h3004 || retired !== r0) begin errors++; $display("FAIL ws_ignore%0d: valid %b pc %h ret %0d want 0 %h %0d", i, instr_valid, pc, retired, 32'h3004, r0); end
        end
        clear_inputs();
        imem_ready = 1'b1;
        imem_rdata = 32'h1234_5678;
        tick();
        imem_ready = 1'b0;
        checks++; if (instr_valid !== 1'b1 || instr !== 32'h1234_5678) begin errors++; $display("FAIL ws_valid: valid %b instr %h want 1 %h", instr_valid, instr, 32'h1234_5678); end
        tick();
        checks++; if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr !== 32'h1234_5678) begin errors++; $display("FAIL ws_hold_stable: valid %b req %b instr %h", instr_valid, imem_req, instr); end
        commit(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checks++; if (imem_addr !== 32'h3008 || retired !== exp_ret) begin errors++; $display("FAIL ws_after: addr %h ret %0d want %h %0d", imem_addr, retired, 32'h3008, exp_ret); end
    endtask

    task automatic test_reset_mid();
        fetch(32'h0800_0C10);
        commit(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        fetch(32'h0);
        checks++; if (pc !== 32'h3040 || instr_valid !== 1'b1) begin errors++; $display("FAIL rm_hold_pre: pc %h valid %b want %h 1", pc, instr_valid, 32'h3040); end
        rst_n = 1'b0;
        tick();
        checks++; if (dut.state_q !== ST_BOOT || pc !== 32'h3000 || instr_valid !== 1'b0 || imem_req !== 1'b0 || retired !== 32'h0) begin
            errors++; $display("FAIL rm_hold: state %0d pc %h valid %b req %b ret %0d", dut.state_q, pc, instr_valid, imem_req, retired); end
        rst_n = 1'b1;
        tick();
        tick();
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rm_fetch_pre: req %b want 1", imem_req); end
        rst_n = 1'b0;
        tick();
        checks++; if (dut.state_q !== ST_BOOT || pc !== 32'h3000 || instr_valid !== 1'b0 || imem_req !== 1'b0) begin
            errors++; $display("FAIL rm_fetch: state %0d pc %h valid %b req %b", dut.state_q, pc, instr_valid, imem_req); end
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        test_reset();
        test_sequential();
        test_branch();
        test_jumps();
        test_wait_states();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
